// File: rtl/mlp_sched.sv
// rtl/mlp_sched.sv - neuron/operand sequencer for a time-multiplexed 2-layer dense MLP
//
// Walks every neuron of layer 1 (D_IN -> D_HID) and layer 2 (D_HID -> D_OUT)
// on one shared MAC: BIAS loads the accumulator, MAC streams the fan-in,
// STORE writes the activated result to the hidden buffer or output register.
// Optional macro: MLP_SCHED_PERF_EN enables the saturating inference counter.
//
// Ports:
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   clear_i                  synchronous soft abort back to IDLE
//   in_valid_i / in_ready_o  input vector handshake (ready only in IDLE)
//   out_valid_o / out_ready_i  output vector handshake
//   busy_o                   any state other than IDLE
//   w_addr_o, b_addr_o       weight / bias memory addresses
//   src_sel_o, src_idx_o     MAC operand source (0 input vector, 1 hidden) and index
//   mac_clr_o, mac_en_o      accumulator load-with-bias / accumulate strobes
//   wr_o, dst_sel_o, dst_idx_o  result write strobe, destination (0 hidden, 1 output), index
//   infer_cnt_o              completed inferences (0 when MLP_SCHED_PERF_EN undefined)

module mlp_sched #(
   parameter int D_IN  = 6,
   parameter int D_HID = 16,
   parameter int D_OUT = 3,
   parameter int WA_W  = $clog2(D_IN*D_HID + D_HID*D_OUT),
   parameter int BA_W  = $clog2(D_HID + D_OUT),
   parameter int IX_W  = $clog2((D_IN > D_HID) ? D_IN : D_HID)
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   input  logic            clear_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic            busy_o,
   output logic [WA_W-1:0] w_addr_o,
   output logic [BA_W-1:0] b_addr_o,
   output logic            src_sel_o,
   output logic [IX_W-1:0] src_idx_o,
   output logic            mac_clr_o,
   output logic            mac_en_o,
   output logic            wr_o,
   output logic            dst_sel_o,
   output logic [IX_W-1:0] dst_idx_o,
   output logic [15:0]     infer_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BIAS,
      S_MAC,
      S_STORE,
      S_DONE
   } state_t;

   localparam logic [IX_W-1:0] LAST_K0 = IX_W'(D_IN - 1);
   localparam logic [IX_W-1:0] LAST_K1 = IX_W'(D_HID - 1);
   localparam logic [IX_W-1:0] LAST_J0 = IX_W'(D_HID - 1);
   localparam logic [IX_W-1:0] LAST_J1 = IX_W'(D_OUT - 1);
   localparam logic [BA_W-1:0] B_OFS1  = BA_W'(D_HID);

   state_t          state_q, state_d;
   logic            layer_q, layer_d;
   logic [IX_W-1:0] j_q, j_d;
   logic [IX_W-1:0] k_q, k_d;
   // Weights of both layers are laid out back to back in neuron-major order,
   // so a single running counter walks the whole store without multipliers.
   logic [WA_W-1:0] w_addr_q, w_addr_d;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q  <= S_IDLE;
         layer_q  <= 1'b0;
         j_q      <= '0;
         k_q      <= '0;
         w_addr_q <= '0;
      end else begin
         state_q  <= state_d;
         layer_q  <= layer_d;
         j_q      <= j_d;
         k_q      <= k_d;
         w_addr_q <= w_addr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      layer_d     = layer_q;
      j_d         = j_q;
      k_d         = k_q;
      w_addr_d    = w_addr_q;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      busy_o      = (state_q != S_IDLE);
      w_addr_o    = '0;
      b_addr_o    = '0;
      src_sel_o   = 1'b0;
      src_idx_o   = '0;
      mac_clr_o   = 1'b0;
      mac_en_o    = 1'b0;
      wr_o        = 1'b0;
      dst_sel_o   = 1'b0;
      dst_idx_o   = '0;

      case (state_q)
         S_IDLE: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               layer_d  = 1'b0;
               j_d      = '0;
               k_d      = '0;
               w_addr_d = '0;
               state_d  = S_BIAS;
            end
         end
         S_BIAS: begin
            mac_clr_o = 1'b1;
            b_addr_o  = layer_q ? (B_OFS1 + BA_W'(j_q)) : BA_W'(j_q);
            k_d       = '0;
            state_d   = S_MAC;
         end
         S_MAC: begin
            mac_en_o  = 1'b1;
            src_sel_o = layer_q;
            src_idx_o = k_q;
            w_addr_o  = w_addr_q;
            w_addr_d  = w_addr_q + WA_W'(1);
            if (k_q == (layer_q ? LAST_K1 : LAST_K0)) begin
               state_d = S_STORE;
            end else begin
               k_d = k_q + IX_W'(1);
            end
         end
         S_STORE: begin
            wr_o      = 1'b1;
            dst_sel_o = layer_q;
            dst_idx_o = j_q;
            if (j_q != (layer_q ? LAST_J1 : LAST_J0)) begin
               j_d     = j_q + IX_W'(1);
               state_d = S_BIAS;
            end else if (!layer_q) begin
               layer_d = 1'b1;
               j_d     = '0;
               state_d = S_BIAS;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            out_valid_o = 1'b1;
            if (out_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort wins over everything, including a pending write in STORE:
      // the abandoned result must never reach the destination.
      if (clear_i) begin
         state_d  = S_IDLE;
         layer_d  = 1'b0;
         j_d      = '0;
         k_d      = '0;
         w_addr_d = '0;
         wr_o     = 1'b0;
      end
   end

`ifdef MLP_SCHED_PERF_EN
   logic [15:0] infer_cnt_q, infer_cnt_d;

   always_comb begin
      infer_cnt_d = infer_cnt_q;
      if ((state_q == S_DONE) && out_ready_i && !clear_i && (infer_cnt_q != 16'hFFFF)) begin
         infer_cnt_d = infer_cnt_q + 16'd1;
      end
   end

   // Only the hard reset clears the counter; soft aborts leave it intact.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         infer_cnt_q <= '0;
      end else begin
         infer_cnt_q <= infer_cnt_d;
      end
   end

   assign infer_cnt_o = infer_cnt_q;
`else
   assign infer_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mlp_sched.sv
// tb/tb_mlp_sched.sv - self-checking bench for mlp_sched against a per-cycle event model

module tb_mlp_sched;

   localparam int D_IN  = 6;
   localparam int D_HID = 16;
   localparam int D_OUT = 3;

   logic       clk_i = 1'b0;
   logic       rstn_i = 1'b0;
   logic       clear_i = 1'b0;
   logic       in_valid_i = 1'b0;
   logic       out_ready_i = 1'b0;
   logic       in_ready_o, out_valid_o, busy_o;
   logic [7:0] w_addr_o;
   logic [4:0] b_addr_o;
   logic       src_sel_o, mac_clr_o, mac_en_o, wr_o, dst_sel_o;
   logic [3:0] src_idx_o, dst_idx_o;
   logic [15:0] infer_cnt_o;

   mlp_sched dut (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .clear_i    (clear_i),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i),
      .busy_o     (busy_o),
      .w_addr_o   (w_addr_o),
      .b_addr_o   (b_addr_o),
      .src_sel_o  (src_sel_o),
      .src_idx_o  (src_idx_o),
      .mac_clr_o  (mac_clr_o),
      .mac_en_o   (mac_en_o),
      .wr_o       (wr_o),
      .dst_sel_o  (dst_sel_o),
      .dst_idx_o  (dst_idx_o),
      .infer_cnt_o(infer_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic       clr;
      logic       en;
      logic       wr;
      logic [7:0] wa;
      logic [4:0] ba;
      logic       ss;
      logic [3:0] si;
      logic       ds;
      logic [3:0] di;
   } ev_t;

   ev_t trace[$];
   int  errors = 0;
   int  checks = 0;
   int  hs_cnt = 0;
   int  n_clr, n_en, n_wr, n_wr_hid;

   // Expected activity of one inference, one entry per cycle starting at cycle 1.
   task automatic build_trace();
      ev_t e;
      trace.delete();
      for (int l = 0; l < 2; l++) begin
         int nj = (l == 0) ? D_HID : D_OUT;
         int nk = (l == 0) ? D_IN : D_HID;
         for (int j = 0; j < nj; j++) begin
            e = '0; e.clr = 1'b1; e.ba = 5'((l == 0) ? j : D_HID + j);
            trace.push_back(e);
            for (int k = 0; k < nk; k++) begin
               e = '0; e.en = 1'b1; e.ss = 1'(l); e.si = 4'(k);
               e.wa = 8'((l == 0) ? j*D_IN + k : D_IN*D_HID + j*D_HID + k);
               trace.push_back(e);
            end
            e = '0; e.wr = 1'b1; e.ds = 1'(l); e.di = 4'(j);
            trace.push_back(e);
         end
      end
   endtask

   function automatic logic [15:0] exp_cnt();
`ifdef MLP_SCHED_PERF_EN
      return (hs_cnt > 65535) ? 16'hFFFF : 16'(hs_cnt);
`else
      return 16'h0000;
`endif
   endfunction

   // Called at a negedge while the DUT should be idle; handshake happens on the next posedge.
   task automatic accept();
      checks++;
      if (in_ready_o !== 1'b1) begin
         errors++; $display("FAIL accept_ready: got %b want 1", in_ready_o);
      end
      in_valid_i = 1'b1;
      clear_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic check_trace(input int from, input int to);
      for (int i = from; i < to; i++) begin
         ev_t e = trace[i];
         checks++;
         if ({mac_clr_o, mac_en_o, wr_o, busy_o, in_ready_o, out_valid_o} !== {e.clr, e.en, e.wr, 3'b100}) begin
            errors++;
            $display("FAIL strobes[%0d]: got clr/en/wr/busy/rdy/ov=%b%b%b%b%b%b want %b%b%b100", i,
                     mac_clr_o, mac_en_o, wr_o, busy_o, in_ready_o, out_valid_o, e.clr, e.en, e.wr);
         end
         if (e.en) begin
            checks++;
            if ({w_addr_o, src_sel_o, src_idx_o} !== {e.wa, e.ss, e.si}) begin
               errors++;
               $display("FAIL mac_addr[%0d]: got w=%0d sel=%b idx=%0d want w=%0d sel=%b idx=%0d", i,
                        w_addr_o, src_sel_o, src_idx_o, e.wa, e.ss, e.si);
            end
         end
         if (e.clr) begin
            checks++;
            if (b_addr_o !== e.ba) begin
               errors++; $display("FAIL b_addr[%0d]: got %0d want %0d", i, b_addr_o, e.ba);
            end
         end
         if (e.wr) begin
            checks++;
            if ({dst_sel_o, dst_idx_o} !== {e.ds, e.di}) begin
               errors++;
               $display("FAIL dst[%0d]: got sel=%b idx=%0d want sel=%b idx=%0d", i, dst_sel_o, dst_idx_o, e.ds, e.di);
            end
         end
         n_clr += int'(mac_clr_o); n_en += int'(mac_en_o); n_wr += int'(wr_o);
         n_wr_hid += int'(wr_o && !dst_sel_o);
         in_valid_i  = 1'($urandom);
         out_ready_i = 1'($urandom);
         @(negedge clk_i);
      end
   endtask

   // At a negedge in DONE: hold off 'delay' cycles, then complete the output handshake.
   task automatic finish_done(input int delay, input bit keep_valid);
      for (int d = 0; d <= delay; d++) begin
         checks++;
         if ({out_valid_o, in_ready_o, busy_o, mac_clr_o, mac_en_o, wr_o} !== 6'b101000) begin
            errors++;
            $display("FAIL done_hold[%0d]: got ov/rdy/busy/clr/en/wr=%b%b%b%b%b%b want 101000", d,
                     out_valid_o, in_ready_o, busy_o, mac_clr_o, mac_en_o, wr_o);
         end
         out_ready_i = (d == delay);
         in_valid_i  = (d == delay) ? keep_valid : 1'b1;
         @(negedge clk_i);
      end
      hs_cnt++;
      out_ready_i = 1'b0;
      checks++;
      if ({out_valid_o, in_ready_o, busy_o} !== 3'b010) begin
         errors++;
         $display("FAIL after_hs: got ov/rdy/busy=%b%b%b want 010", out_valid_o, in_ready_o, busy_o);
      end
      checks++;
      if (infer_cnt_o !== exp_cnt()) begin
         errors++; $display("FAIL infer_cnt: got %0d want %0d", infer_cnt_o, exp_cnt());
      end
   endtask

   task automatic check_idle(input string name);
      checks++;
      if ({in_ready_o, out_valid_o, busy_o, mac_clr_o, mac_en_o, wr_o} !== 6'b100000) begin
         errors++;
         $display("FAIL %s: got rdy/ov/busy/clr/en/wr=%b%b%b%b%b%b want 100000", name,
                  in_ready_o, out_valid_o, busy_o, mac_clr_o, mac_en_o, wr_o);
      end
   endtask

   task automatic check_reset_vals(input string name);
      checks++;
      if ({in_ready_o, out_valid_o, busy_o, mac_clr_o, mac_en_o, wr_o, src_sel_o, dst_sel_o,
           w_addr_o, b_addr_o, src_idx_o, dst_idx_o, infer_cnt_o} !== {8'b1000_0000, 37'd0}) begin
         errors++;
         $display("FAIL %s: got rdy/ov/busy/clr/en/wr=%b%b%b%b%b%b w=%0d b=%0d cnt=%0d want 100000 w=0 b=0 cnt=0",
                  name, in_ready_o, out_valid_o, busy_o, mac_clr_o, mac_en_o, wr_o, w_addr_o, b_addr_o, infer_cnt_o);
      end
   endtask

   task automatic test_reset();
      in_valid_i = 1'b1; out_ready_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      check_reset_vals("reset_state");
      in_valid_i = 1'b0; out_ready_i = 1'b0;
      rstn_i = 1'b1;
      @(negedge clk_i);
      check_idle("reset_release");
   endtask

   task automatic test_single(input int delay);
      n_clr = 0; n_en = 0; n_wr = 0; n_wr_hid = 0;
      accept();
      check_trace(0, trace.size());
      finish_done(delay, 1'b0);
      checks++;
      if ({n_clr, n_en, n_wr, n_wr_hid} !== {32'd19, 32'd144, 32'd19, 32'd16}) begin
         errors++;
         $display("FAIL counts: got clr=%0d en=%0d wr=%0d wr_hid=%0d want 19 144 19 16", n_clr, n_en, n_wr, n_wr_hid);
      end
   endtask

   task automatic test_backpressure();
      accept();
      check_trace(0, trace.size());
      finish_done(50, 1'b1);
      // in_valid_i is still high: next vector is taken on the following edge.
      accept();
      in_valid_i = 1'b0;
      check_trace(0, trace.size());
      finish_done(0, 1'b0);
   endtask

   task automatic test_clear();
      // Abort in layer 2, neuron 1, operand 5.
      accept();
      check_trace(0, 152);
      clear_i = 1'b1;
      #1;
      checks++;
      if ({mac_en_o, wr_o} !== 2'b10) begin
         errors++; $display("FAIL clear_mac: got en/wr=%b%b want 10", mac_en_o, wr_o);
      end
      @(negedge clk_i);
      clear_i = 1'b0; in_valid_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check_idle("clear_idle");
         @(negedge clk_i);
      end
      // Abort exactly on the last layer-1 STORE: its write must be suppressed.
      accept();
      check_trace(0, 127);
      clear_i = 1'b1;
      #1;
      checks++;
      if (wr_o !== 1'b0) begin
         errors++; $display("FAIL clear_store_wr: got %b want 0", wr_o);
      end
      @(negedge clk_i);
      // Clear in IDLE with a vector offered: not accepted.
      in_valid_i = 1'b1;
      @(negedge clk_i);
      clear_i = 1'b0; in_valid_i = 1'b0;
      check_idle("clear_in_idle");
      @(negedge clk_i);
      check_idle("clear_in_idle2");
      // Clear in DONE together with out_ready: no handshake counted.
      accept();
      check_trace(0, trace.size());
      out_ready_i = 1'b0;
      @(negedge clk_i);
      out_ready_i = 1'b1; clear_i = 1'b1;
      @(negedge clk_i);
      out_ready_i = 1'b0; clear_i = 1'b0;
      check_idle("clear_done");
      checks++;
      if (infer_cnt_o !== exp_cnt()) begin
         errors++; $display("FAIL clear_done_cnt: got %0d want %0d", infer_cnt_o, exp_cnt());
      end
      test_single($urandom_range(0, 4));
   endtask

   task automatic test_async_reset();
      accept();
      check_trace(0, 60);
      #2 rstn_i = 1'b0;
      hs_cnt = 0;
      #1;
      check_reset_vals("async_reset");
      @(negedge clk_i);
      check_reset_vals("async_reset_hold");
      rstn_i = 1'b1; in_valid_i = 1'b0;
      @(negedge clk_i);
      check_idle("async_release");
      test_single(0);
   endtask

   task automatic test_back_to_back();
      time t_prev = 0;
      for (int v = 0; v < 3; v++) begin
         accept();
         in_valid_i = 1'b0;
         check_trace(0, trace.size());
         if (v > 0) begin
            checks++;
            if ($time - t_prev != 184 * 10) begin
               errors++; $display("FAIL b2b_period: got %0t want %0d", $time - t_prev, 1840);
            end
         end
         t_prev = $time;
         finish_done(0, 1'b1);
      end
      in_valid_i = 1'b0;
   endtask

   initial begin
      build_trace();
      test_reset();
      test_single(0);
      test_backpressure();
      test_clear();
      test_async_reset();
      test_back_to_back();
      test_single($urandom_range(1, 6));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mlp_sched.md
Name: mlp_sched

Overview:
- Sequencer for a time-multiplexed 2-layer dense MLP (D_IN -> D_HID -> D_OUT) sharing one 8-bit MAC unit.
- Accepts an input-vector handshake and walks every neuron of both layers. Per neuron it drives:
  - weight/bias memory addresses,
  - MAC clear/accumulate controls,
  - result write strobes to the hidden buffer or the output register.
- Sits between the sensor front-end (input vector) and the weight store/MAC datapath.
- Presents a valid/ready result handshake to the downstream classifier.

Parameters:
- D_IN, 6, input vector length (layer-1 fan-in)
- D_HID, 16, hidden neurons (layer-1 fan-out, layer-2 fan-in)
- D_OUT, 3, output neurons
- WA_W, $clog2(D_IN*D_HID+D_HID*D_OUT), weight address width (8 at defaults)
- BA_W, $clog2(D_HID+D_OUT), bias address width (5 at defaults)
- IX_W, $clog2(max(D_IN,D_HID)), source/destination index width (4 at defaults)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous soft abort
- in_valid_i  in  1  input vector valid
- in_ready_o  out  1  scheduler idle, can accept
- out_valid_o  out  1  output vector complete
- out_ready_i  in  1  downstream accepts output
- busy_o  out  1  high in any state other than IDLE
- w_addr_o  out  WA_W  weight address
- b_addr_o  out  BA_W  bias address
- src_sel_o  out  1  MAC operand source: 0 = input vector, 1 = hidden buffer
- src_idx_o  out  IX_W  operand index within source
- mac_clr_o  out  1  load accumulator with bias[b_addr_o]
- mac_en_o  out  1  accumulate src[src_idx_o]*w[w_addr_o]
- wr_o  out  1  write activated accumulator to destination
- dst_sel_o  out  1  write destination: 0 = hidden buffer, 1 = output register
- dst_idx_o  out  IX_W  destination index
- infer_cnt_o  out  16  completed inferences (see Optional Feature)

Behaviour:
- Reset (rstn_i low, async):
  - state = IDLE; all counters 0.
  - Outputs: in_ready_o=1, all other outputs 0.
- All outputs are registered-state decodes (Moore); no combinational path from in_valid_i or out_ready_i to any output.
- FSM states: IDLE, BIAS, MAC, STORE, DONE. Layer flag L (0/1), neuron counter j, operand counter k.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i: L=0, j=0 -> BIAS.
- BIAS (1 cycle): mac_clr_o=1.
  - b_addr_o = j for L=0; D_HID+j for L=1.
  - k=0 -> MAC.
- MAC (N cycles; N = D_IN for L=0, D_HID for L=1):
  - mac_en_o=1, src_sel_o=L, src_idx_o=k.
  - w_addr_o = j*D_IN+k for L=0; D_IN*D_HID + j*D_HID + k for L=1.
  - k increments; after k=N-1 -> STORE.
- STORE (1 cycle): wr_o=1, dst_sel_o=L, dst_idx_o=j.
  - If j < last (D_HID-1 for L=0, D_OUT-1 for L=1): j++ -> BIAS.
  - Else if L=0: L=1, j=0 -> BIAS.
  - Else -> DONE.
- DONE:
  - out_valid_o=1, held stable until out_ready_i.
  - On out_valid_o & out_ready_i -> IDLE.
- Latency at defaults:
  - Handshake at edge 0; first BIAS in cycle 1.
  - Layer 1: 16*(6+2)=128 cycles. Layer 2: 3*(16+2)=54 cycles.
  - out_valid_o first high in cycle 183.
  - Back-to-back throughput: one vector per 184 cycles minimum.
- Only one inference in flight: in_ready_o=0 in all states except IDLE, including DONE under backpressure.
- Only one of mac_clr_o, mac_en_o, wr_o is high in any cycle.
- clear_i (synchronous, highest priority after reset):
  - From any state -> IDLE next cycle; counters zeroed.
  - No wr_o issued in the clear cycle or after it.
  - out_valid_o drops; infer_cnt_o is not incremented.
  - clear_i in IDLE with in_valid_i high: the vector is not accepted.
- Async reset mid-inference: immediate return to reset values; partial hidden-buffer writes are abandoned and are not the scheduler's concern.
- Address arithmetic wraps nowhere: max w_addr_o = D_IN*D_HID + D_HID*D_OUT - 1 (143), max b_addr_o = D_HID+D_OUT-1 (18).

Optional Feature:
- Macro MLP_SCHED_PERF_EN.
- Defined:
  - infer_cnt_o increments on each out_valid_o & out_ready_i handshake.
  - Saturates at 16'hFFFF.
  - Reset to 0 by rstn_i only; clear_i does not affect it.
- Undefined: infer_cnt_o tied to 0; no counter flops.

Test Plan:
- Reset then single vector, out_ready_i=1:
  - mac_clr_o pulses 19 times and wr_o 19 times (16 with dst_sel_o=0, 3 with dst_sel_o=1).
  - mac_en_o high 96+48=144 cycles.
  - out_valid_o high in cycle 183, for 1 cycle.
- Address sweep: w_addr_o takes every value 0..143 exactly once, in order; b_addr_o follows 0..15 then 16..18; src_sel_o=1 exactly when w_addr_o >= 96.
- Backpressure: out_ready_i=0 for 50 cycles after out_valid_o -> out_valid_o held for 50 cycles, in_ready_o=0 throughout with in_valid_i=1, no MAC strobes; vector accepted the cycle after out_ready_i=1.
- clear_i asserted in layer 2, j=1, MAC k=5 -> IDLE next cycle, no further wr_o, in_ready_o=1. A new vector then completes normally in 183 cycles.
- rstn_i pulsed low mid-layer-1 (j=7) -> all outputs at reset values asynchronously; after release in_ready_o=1 and a fresh run matches the first scenario.
- MLP_SCHED_PERF_EN defined: 3 back-to-back inferences -> infer_cnt_o=3. Preload to 16'hFFFE plus 3 handshakes -> 16'hFFFF. Macro undefined -> infer_cnt_o stays 0.
